// File: rtl/clock_period_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clock_period_meter_pkg;
   typedef enum logic {WAIT_FIRST, MEASURE} state_e;

   localparam int DEF_CNT_W    = 26;
   localparam int DEF_TIMEOUT  = 50000000;
   localparam int BOARD_CLK_HZ = 50000000;
endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level through SYNC_STAGES flops and flags its edges.
// rise/fall are one-cycle pulses derived from the synced level and a previous-sample flop.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock_in,
   input  logic reset,
   input  logic async_in,
   output logic synced,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], async_in};

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= synced;
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];
   assign rise   = synced & ~prev_q;
   assign fall   = ~synced & prev_q;
endmodule

// File: rtl/clock_period_meter.sv
// Measures sig_in period in clock_in cycles, with a one-cycle strobe per period and loss-of-signal timeout.
// Define CLOCK_PERIOD_METER_HIGH_TIME_EN to add high_out (high time of the last measured period).
module clock_period_meter
   import clock_period_meter_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             timeout,
   output logic             locked
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
   ,
   output logic [CNT_W-1:0] high_out
`endif
);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   logic synced, rise, fall;
   logic capture, expire;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             locked_q, locked_d;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock_in (clock_in),
      .reset    (reset),
      .async_in (sig_in),
      .synced   (synced),
      .rise     (rise),
      .fall     (fall)
   );

   // A rise on the TIMEOUT cycle is a valid capture, so expiry needs no rise.
   assign capture = (state_q == MEASURE) && rise;
   assign expire  = (state_q == MEASURE) && !rise && (cnt_q == TO_VAL);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      locked_d  = locked_q;
      case (state_q)
         WAIT_FIRST: begin
            if (rise) begin
               cnt_d   = ONE;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (capture) begin
               period_d  = cnt_q;
               valid_d   = 1'b1;
               cnt_d     = ONE;
               locked_d  = 1'b1;
               timeout_d = 1'b0;
            end else if (expire) begin
               period_d  = '0;
               cnt_d     = '0;
               locked_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = WAIT_FIRST;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: state_d = WAIT_FIRST;
      endcase
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         state_q   <= WAIT_FIRST;
         cnt_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         locked_q  <= locked_d;
      end
   end

   assign period_out   = period_q;
   assign period_valid = valid_q;
   assign timeout      = timeout_q;
   assign locked       = locked_q;

`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
   logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0] high_lat_q, high_lat_d;
   logic [CNT_W-1:0] high_q, high_d;

   // High time is latched on the fall and only published alongside the next period strobe.
   always_comb begin
      high_cnt_d = high_cnt_q;
      high_lat_d = high_lat_q;
      high_d     = high_q;
      if (rise) begin
         high_cnt_d = ONE;
      end else if (synced && (high_cnt_q != TO_VAL)) begin
         high_cnt_d = high_cnt_q + ONE;
      end
      if (fall) begin
         high_lat_d = high_cnt_q;
      end
      if (capture) begin
         high_d = high_lat_q;
      end else if (expire) begin
         high_d     = '0;
         high_lat_d = '0;
      end
   end

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         high_cnt_q <= '0;
         high_lat_q <= '0;
         high_q     <= '0;
      end else begin
         high_cnt_q <= high_cnt_d;
         high_lat_q <= high_lat_d;
         high_q     <= high_d;
      end
   end

   assign high_out = high_q;
`else
   logic unused_edge_info;
   assign unused_edge_info = synced ^ fall;
`endif
endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter (TIMEOUT=1000, CNT_W=16, SYNC_STAGES=2).
// Strobes and timeout edges are logged on the falling clock edge and compared per scenario task.
module tb_clock_period_meter;
   localparam int CNT_W = 16;
   localparam int TO    = 1000;

   logic             clk = 1'b0;
   logic             rst;
   logic             sig;
   logic [CNT_W-1:0] per;
   logic             vld;
   logic             tmo;
   logic             lk;
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
   logic [CNT_W-1:0] hi;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int   s_cyc[$];
   int   s_per[$];
   logic s_to[$];
   logic s_lk[$];
   int   s_hi[$];
   int   rise_q[$];
   int   last_strobe = 0;
   int   to_rise     = 0;
   int   to_cnt      = 0;
   logic to_prev     = 1'b0;

   clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(2)) dut (
      .clock_in     (clk),
      .reset        (rst),
      .sig_in       (sig),
      .period_out   (per),
      .period_valid (vld),
      .timeout      (tmo),
      .locked       (lk)
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
      ,
      .high_out     (hi)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vld === 1'b1) begin
         s_cyc.push_back(cyc);
         s_per.push_back(int'(per));
         s_to.push_back(tmo);
         s_lk.push_back(lk);
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
         s_hi.push_back(int'(hi));
`endif
         last_strobe = cyc;
      end
      if (tmo === 1'b1 && to_prev !== 1'b1) begin
         to_rise = cyc;
         to_cnt++;
      end
      to_prev = tmo;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // sig_in changes 1 time unit after a rising clock edge; rise_q logs the cycle of each sig_in rise.
   task automatic drive_wave(input int h, input int l, input int n);
      for (int p = 0; p < n; p++) begin
         sig = 1'b1;
         rise_q.push_back(cyc);
         step(h);
         sig = 1'b0;
         step(l);
      end
   endtask

   task automatic clear_log();
      s_cyc.delete();
      s_per.delete();
      s_to.delete();
      s_lk.delete();
      s_hi.delete();
      rise_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sig = 1'b0;
      step(3);
      total++; if (per !== 16'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", per); end
      total++; if (vld !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", vld); end
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", tmo); end
      total++; if (lk !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", lk); end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_lock();
      clear_log();
      drive_wave(25, 25, 4);
      total++; if (s_per.size() !== 3) begin bad++; $display("FAIL lock_count: got %0d want 3", s_per.size()); end
      for (int i = 0; i < s_per.size(); i++) begin
         total++; if (s_per[i] !== 50) begin bad++; $display("FAIL lock_period[%0d]: got %0d want 50", i, s_per[i]); end
         total++; if (s_lk[i] !== 1'b1) begin bad++; $display("FAIL lock_locked[%0d]: got %b want 1", i, s_lk[i]); end
         total++; if (s_to[i] !== 1'b0) begin bad++; $display("FAIL lock_timeout[%0d]: got %b want 0", i, s_to[i]); end
      end
      // Strobe is visible in the fourth clock period counting the one in which sig_in rose.
      if (s_cyc.size() >= 2) begin
         total++; if (s_cyc[0] - rise_q[1] !== 3) begin bad++; $display("FAIL lock_latency0: got %0d want 3", s_cyc[0] - rise_q[1]); end
         total++; if (s_cyc[1] - rise_q[2] !== 3) begin bad++; $display("FAIL lock_latency1: got %0d want 3", s_cyc[1] - rise_q[2]); end
      end
   endtask

   task automatic test_period_change();
      int exp_p[5];
      exp_p = '{50, 32, 14, 14, 14};
      clear_log();
      drive_wave(25, 7, 1);
      drive_wave(7, 7, 4);
      total++; if (s_per.size() !== 5) begin bad++; $display("FAIL chg_count: got %0d want 5", s_per.size()); end
      for (int i = 0; i < 5 && i < s_per.size(); i++) begin
         total++; if (s_per[i] !== exp_p[i]) begin bad++; $display("FAIL chg_period[%0d]: got %0d want %0d", i, s_per[i], exp_p[i]); end
      end
   endtask

   task automatic test_timeout();
      int ls, tc0;
      ls  = last_strobe;
      tc0 = to_cnt;
      step(1010);
      total++; if (to_cnt !== tc0 + 1) begin bad++; $display("FAIL to_events: got %0d want %0d", to_cnt, tc0 + 1); end
      total++; if (to_rise - ls !== TO) begin bad++; $display("FAIL to_delay: got %0d want %0d", to_rise - ls, TO); end
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL to_level: got %b want 1", tmo); end
      total++; if (lk !== 1'b0) begin bad++; $display("FAIL to_locked: got %b want 0", lk); end
      total++; if (per !== 16'd0) begin bad++; $display("FAIL to_period: got %0d want 0", per); end
      clear_log();
      drive_wave(25, 25, 1);
      total++; if (s_per.size() !== 0) begin bad++; $display("FAIL rearm_count: got %0d want 0", s_per.size()); end
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL rearm_timeout: got %b want 1", tmo); end
      total++; if (lk !== 1'b0) begin bad++; $display("FAIL rearm_locked: got %b want 0", lk); end
      drive_wave(25, 25, 1);
      total++; if (s_per.size() !== 1) begin bad++; $display("FAIL relock_count: got %0d want 1", s_per.size()); end
      if (s_per.size() >= 1) begin
         total++; if (s_per[0] !== 50) begin bad++; $display("FAIL relock_period: got %0d want 50", s_per[0]); end
         total++; if (s_to[0] !== 1'b0) begin bad++; $display("FAIL relock_timeout: got %b want 0", s_to[0]); end
         total++; if (s_lk[0] !== 1'b1) begin bad++; $display("FAIL relock_locked: got %b want 1", s_lk[0]); end
      end
   endtask

   task automatic test_boundary();
      int tc0;
      int exp_p[4];
      exp_p = '{50, 1000, 1000, 1000};
      clear_log();
      tc0 = to_cnt;
      drive_wave(500, 500, 3);
      total++; if (to_cnt !== tc0) begin bad++; $display("FAIL bnd_no_timeout: got %0d events want 0", to_cnt - tc0); end
      drive_wave(501, 501, 1);
      step(5);
      total++; if (s_per.size() !== 4) begin bad++; $display("FAIL bnd_count: got %0d want 4", s_per.size()); end
      for (int i = 0; i < 4 && i < s_per.size(); i++) begin
         total++; if (s_per[i] !== exp_p[i]) begin bad++; $display("FAIL bnd_period[%0d]: got %0d want %0d", i, s_per[i], exp_p[i]); end
      end
      total++; if (to_cnt !== tc0 + 1) begin bad++; $display("FAIL bnd_501_timeout: got %0d events want 1", to_cnt - tc0); end
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL bnd_501_level: got %b want 1", tmo); end
   endtask

   task automatic test_reset_mid();
      drive_wave(25, 25, 2);
      sig = 1'b1;
      step(10);
      #3;
      total++; if (lk !== 1'b1) begin bad++; $display("FAIL mid_pre_locked: got %b want 1", lk); end
      total++; if (per !== 16'd50) begin bad++; $display("FAIL mid_pre_period: got %0d want 50", per); end
      rst = 1'b1;
      sig = 1'b0;
      #2;
      total++; if (per !== 16'd0) begin bad++; $display("FAIL mid_period: got %0d want 0", per); end
      total++; if (vld !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", vld); end
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL mid_timeout: got %b want 0", tmo); end
      total++; if (lk !== 1'b0) begin bad++; $display("FAIL mid_locked: got %b want 0", lk); end
      step(2);
      rst = 1'b0;
      step(2);
      clear_log();
      drive_wave(25, 25, 3);
      total++; if (s_per.size() !== 2) begin bad++; $display("FAIL mid_count: got %0d want 2", s_per.size()); end
      if (s_per.size() >= 1) begin
         total++; if (s_cyc[0] !== rise_q[1] + 3) begin bad++; $display("FAIL mid_first_strobe: got %0d want %0d", s_cyc[0], rise_q[1] + 3); end
         total++; if (s_per[0] !== 50) begin bad++; $display("FAIL mid_period_after: got %0d want 50", s_per[0]); end
      end
   endtask

`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
   task automatic test_high_time();
      int exp_h[3];
      exp_h = '{25, 30, 30};
      clear_log();
      drive_wave(30, 20, 3);
      total++; if (s_per.size() !== 3) begin bad++; $display("FAIL hi_count: got %0d want 3", s_per.size()); end
      for (int i = 0; i < 3 && i < s_per.size(); i++) begin
         total++; if (s_per[i] !== 50) begin bad++; $display("FAIL hi_period[%0d]: got %0d want 50", i, s_per[i]); end
         total++; if (s_hi[i] !== exp_h[i]) begin bad++; $display("FAIL hi_high[%0d]: got %0d want %0d", i, s_hi[i], exp_h[i]); end
      end
      step(1010);
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL hi_timeout: got %b want 1", tmo); end
      total++; if (hi !== 16'd0) begin bad++; $display("FAIL hi_cleared: got %0d want 0", hi); end
   endtask
`endif

   initial begin
      test_reset();
      test_lock();
      test_period_change();
      test_timeout();
      test_boundary();
      test_reset_mid();
`ifdef CLOCK_PERIOD_METER_HIGH_TIME_EN
      test_high_time();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
